uart_tx_arbiter: RTL

- Shares the single `uarttx` transmitter between two byte requesters.
  - Requester 0 is the CPU `SNDA` path; requester 1 is the debug/status source.
- Buffers accepted bytes in a small FIFO and admits them by round-robin arbitration.
- Drives the transmitter's `tx_start`/`tx_byte`/`tx_ready` handshake so a byte is never launched while the transmitter is busy.
- Sits between the CPU control logic and `uarttx`, replacing the direct `tx_start`/`tx_byte` connection.

---
 rtl/uart_tx_arbiter.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uarttx transmitter between two byte requesters
// (port 0 = CPU SNDA path, port 1 = debug/status source). Accepted bytes are
// queued in a small circular FIFO and launched through the tx_start/tx_byte/
// tx_ready handshake, never while the transmitter reports busy.
// Build option: define UART_TX_ARB_ROUND_ROBIN_EN for round-robin tie
// breaking; without it port 0 always wins a tie (fixed priority).
module uart_tx_arbiter #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req0,
  input  logic [WIDTH-1:0]              data0,
  output logic                          ack0,
  input  logic                          req1,
  input  logic [WIDTH-1:0]              data1,
  output logic                          ack1,
  output logic                          tx_start,
  output logic [WIDTH-1:0]              tx_byte,
  input  logic                          tx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_LAUNCH    = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [1:0]       state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [WIDTH-1:0] tx_byte_q, tx_byte_d;

  logic             full;
  logic             grant0, grant1;
  logic             push, pop;
  logic [WIDTH-1:0] push_data;

  // Fullness is judged on the pre-edge count, so a pop on the same edge
  // never frees a slot early.
  assign full = (count_q == FULL_CNT);

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;

  // Round-robin grant: on a tie the port that did not win last time goes.
  always_comb begin
    grant0 = req0 & (~req1 | last_q);
    grant1 = req1 & (~req0 | ~last_q);
  end

  // Remember the most recent grantee; only real writes count as grants.
  always_comb begin
    last_d = last_q;
    if (ack0) begin
      last_d = 1'b0;
    end else if (ack1) begin
      last_d = 1'b1;
    end
  end

  // Reset value 1 lets port 0 win the very first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority grant: port 1 only goes when port 0 is silent.
  always_comb begin
    grant0 = req0;
    grant1 = req1 & ~req0;
  end
`endif

  // Acks are combinational and mark the cycle whose closing edge writes.
  always_comb begin
    ack0      = grant0 & ~full & ~rst;
    ack1      = grant1 & ~full & ~rst;
    push      = ack0 | ack1;
    push_data = ack0 ? data0 : data1;
  end

  // Output FSM: pop only on IDLE->LAUNCH, hold tx_start until the
  // transmitter drops tx_ready, then wait for it to come back idle.
  always_comb begin
    state_d    = state_q;
    tx_start_d = tx_start_q;
    tx_byte_d  = tx_byte_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((count_q != '0) && tx_ready) begin
          pop        = 1'b1;
          tx_byte_d  = mem_q[rd_ptr_q];
          tx_start_d = 1'b1;
          state_d    = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (!tx_ready) begin
          tx_start_d = 1'b0;
          state_d    = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        tx_start_d = 1'b0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Pointer and occupancy update; pointers wrap naturally at the
  // power-of-two depth, and push+pop together leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset drops any queued bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      tx_start_q <= tx_start_d;
      tx_byte_q  <= tx_byte_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage is data only; stale entries are unreachable after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign tx_start   = tx_start_q;
  assign tx_byte    = tx_byte_q;
  assign fifo_count = count_q;
  assign busy       = (state_q != ST_IDLE) || (count_q != '0);

endmodule
